param_register_file: RTL and testbench
======================================

// Module: param_register_file
// PURPOSE
//   Next-generation MIPS register file: parametrised data width, depth and read-port count.
//   Synchronous write and asynchronous multi-port read.
//   Register 0 is hardwired to zero.
//   A sequential clear engine zeroes every entry after reset.
//   Sits in the ID stage: read ports feed the ALU operand muxes; the write port is driven by WB.
// PARAMETERS
//   DATA_W  32  register width in bits
//   DEPTH   32  number of registers (>=2); ADDR_W = $clog2(DEPTH) is a localparam
//   NUM_RD  2   number of independent read ports (>=1)
// PORTS
//   clk             in   1              single clock; all state updates on posedge
//   rst             in   1              synchronous, active-high reset
//   ReadRegister    in   NUM_RD*ADDR_W  read addresses; port k = [k*ADDR_W +: ADDR_W]
//   ReadData        out  NUM_RD*DATA_W  read data; port k = [k*DATA_W +: DATA_W]
//   WriteReg        in   ADDR_W         write address
//   WriteData       in   DATA_W         write data
//   RegWriteActive  in   1              1 = write on this posedge, 0 = no write
//   Ready           out  1              1 = clear sequence done, writes are accepted
// BEHAVIOUR
//   - Clock/reset: one clock, clk; reset rst is synchronous and active-high.
//   - State machine: CLEAR, RUN. A clear counter ClrPtr is ADDR_W bits wide.
//   - Reset (rst=1 at posedge):
//     - state <= CLEAR, ClrPtr <= 0, Ready <= 0.
//     - rst dominates all other inputs, including any RegWriteActive in the same cycle.
//   - CLEAR:
//     - Each posedge writes 0 to RegFile[ClrPtr] and increments ClrPtr.
//     - After the posedge that writes entry DEPTH-1: state <= RUN and Ready <= 1.
//     - Total: exactly DEPTH cycles after rst deasserts.
//     - RegWriteActive is ignored (write dropped, not queued).
//     - All ReadData ports return 0.
//   - Reset during CLEAR restarts the sequence at ClrPtr=0. Same for reset during RUN.
//   - RUN: on posedge, if RegWriteActive=1, WriteReg!=0 and WriteReg<DEPTH, then RegFile[WriteReg] <= WriteData.
//   - Dropped writes:
//     - Writes to register 0 are dropped.
//     - Writes to addresses >= DEPTH are dropped (non-power-of-2 DEPTH).
//   - Reads:
//     - Combinational, zero latency.
//     - ReadData[k] = 0 if ReadRegister[k]==0 or ReadRegister[k]>=DEPTH; otherwise RegFile[ReadRegister[k]].
//   - Any number of ports may read the same address in one cycle; all return identical data.
//   - Same-cycle write and read of one address: governed by REGFILE_BYPASS_EN (see CONFIGURATION).
//   - Post-reset contents: every register reads 0 once Ready=1. No preset values.
//   - Outputs are never X after the first reset. Before the first reset they are undefined.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - In RUN, for each read port k: if RegWriteActive=1, WriteReg!=0, WriteReg<DEPTH and
//       ReadRegister[k]==WriteReg, then ReadData[k] = WriteData combinationally.
//     - The write is seen in the same cycle, which removes the WB->ID hazard.
//     - Register 0 and CLEAR state never bypass.
//   REGFILE_BYPASS_EN undefined:
//     - ReadData[k] returns the pre-write stored value during the write cycle.
//     - The new value appears the cycle after the posedge.
// TESTING
//   1. Pulse rst 1 cycle.
//      -> Ready=0 for exactly 32 cycles, then Ready=1.
//      -> All 32 registers read 0 on both ports.
//   2. Ready=1; write 0x0010_0004 to r2, then 0x0010_0005 to r3.
//      -> Next cycle: port0=r2 reads 0x0010_0004 and port1=r3 reads 0x0010_0005.
//   3. Write 0xDEAD_BEEF to r0.
//      -> r0 reads 0 on all ports.
//      -> No other register changes.
//   4. Same cycle: write 0x1234_5678 to r7 and read r7 on port0.
//      -> With REGFILE_BYPASS_EN: port0 = 0x1234_5678 that cycle.
//      -> Without: port0 = old value that cycle, 0x1234_5678 the next.
//   5. Assert rst at clear cycle 10, with RegWriteActive=1 to r5.
//      -> Clear restarts; Ready rises 32 cycles after rst drops.
//      -> r5 reads 0.
//   6. DEPTH=24, NUM_RD=3: write 0xA5A5_A5A5 to address 30; read 30 and 23 on ports 0..2.
//      -> Address 30 reads 0.
//      -> 23 reads its stored value.
//      -> Ready rises 24 cycles after reset.

Source files
------------

// File: rtl/param_register_file.sv
// Parametrised MIPS register file: synchronous write, asynchronous multi-port read, r0 hardwired to zero,
// sequential post-reset clear. Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module param_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] ReadRegister,
  output logic [NUM_RD*DATA_W-1:0]     ReadData,
  input  logic [$clog2(DEPTH)-1:0]     WriteReg,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic                         RegWriteActive,
  output logic                         Ready
);

  localparam int unsigned     ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ClrPtr;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                wr_ok;

  // A write is architecturally visible only to a real, nonzero register.
  assign wr_ok = RegWriteActive && (WriteReg != '0) && ({1'b0, WriteReg} < DEPTH_A);

  // Clear engine and write port; reset leaves storage alone and restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      ClrPtr <= '0;
      Ready  <= 1'b0;
    end else if (state == CLEAR) begin
      regs[ClrPtr] <= '0;
      if (ClrPtr == LAST) begin
        state <= RUN;
        Ready <= 1'b1;
      end else begin
        ClrPtr <= ClrPtr + ADDR_W'(1);
      end
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] val;

    assign ra  = ReadRegister[k*ADDR_W +: ADDR_W];
    assign hit = (state == RUN) && (ra != '0) && ({1'b0, ra} < DEPTH_A);
`ifdef REGFILE_BYPASS_EN
    assign val = (wr_ok && (ra == WriteReg)) ? WriteData : regs[ra];
`else
    assign val = regs[ra];
`endif
    assign ReadData[k*DATA_W +: DATA_W] = hit ? val : '0;
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file: a default 32x32/2-port instance and a 24-deep 3-port instance.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [9:0]  rr = '0;
  logic [63:0] rd;
  logic [4:0]  wr = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic        ready;

  logic [14:0] rr24 = '0;
  logic [95:0] rd24;
  logic [4:0]  wr24 = '0;
  logic [31:0] wd24 = '0;
  logic        we24 = 1'b0;
  logic        ready24;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  param_register_file dut (
    .clk(clk), .rst(rst), .ReadRegister(rr), .ReadData(rd),
    .WriteReg(wr), .WriteData(wd), .RegWriteActive(we), .Ready(ready)
  );

  param_register_file #(.DATA_W(32), .DEPTH(24), .NUM_RD(3)) dut24 (
    .clk(clk), .rst(rst), .ReadRegister(rr24), .ReadData(rd24),
    .WriteReg(wr24), .WriteData(wd24), .RegWriteActive(we24), .Ready(ready24)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int first32;
    int first24;
    logic [31:0] exp_p0;

    // 1: reset, clear duration for both depths, all registers zero
    pulse_rst();
    check("ready_after_rst", 64'(ready), 64'd0);
    check("ready24_after_rst", 64'(ready24), 64'd0);
    rr = {5'd3, 5'd1};
    #1;
    check("clear_reads_zero", rd, 64'd0);
    first32 = 0;
    first24 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready && first32 == 0) first32 = i;
      if (ready24 && first24 == 0) first24 = i;
    end
    check("clear_len_32", 64'(first32), 64'd32);
    check("clear_len_24", 64'(first24), 64'd24);
    for (int i = 0; i < 32; i++) begin
      rr = {5'(31 - i), 5'(i)};
      #1;
      check("post_clear_zero", rd, 64'd0);
    end

    // 2: back-to-back writes then dual-port read
    we = 1'b1; wr = 5'd2; wd = 32'h0010_0004;
    tick();
    wr = 5'd3; wd = 32'h0010_0005;
    tick();
    we = 1'b0;
    rr = {5'd3, 5'd2};
    #1;
    check("r2_r3", rd, {32'h0010_0005, 32'h0010_0004});

    // 3: r0 write is dropped and never bypasses
    we = 1'b1; wr = 5'd0; wd = 32'hDEAD_BEEF;
    rr = {5'd0, 5'd0};
    #1;
    check("r0_same_cycle", rd, 64'd0);
    tick();
    we = 1'b0;
    #1;
    check("r0_after", rd, 64'd0);
    rr = {5'd3, 5'd2};
    #1;
    check("r2_r3_untouched", rd, {32'h0010_0005, 32'h0010_0004});

    // 4: same-cycle write/read of r7 over a known old value
    we = 1'b1; wr = 5'd7; wd = 32'h0BAD_0007;
    tick();
    wd = 32'h1234_5678;
    rr = {5'd7, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_p0 = 32'h1234_5678;
`else
    exp_p0 = 32'h0BAD_0007;
`endif
    check("r7_write_cycle", rd, {exp_p0, exp_p0});
    tick();
    we = 1'b0;
    #1;
    check("r7_next_cycle", rd, {32'h1234_5678, 32'h1234_5678});

    // 5: reset mid-clear with a write pending to r5
    we = 1'b1; wr = 5'd5; wd = 32'h0000_0055;
    tick();
    we = 1'b0;
    rr = {5'd7, 5'd5};
    #1;
    check("r5_preset", rd, {32'h1234_5678, 32'h0000_0055});
    pulse_rst();
    we = 1'b1; wd = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) check("r5_masked_in_clear", rd, 64'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    first32 = 0;
    for (int i = 1; i <= 40 && !ready; i++) begin
      tick();
      if (ready) first32 = i;
    end
    we = 1'b0;
    check("restart_len_32", 64'(first32), 64'd32);
    #1;
    check("r5_r7_cleared", rd, 64'd0);

    // 6: out-of-range addresses on a 24-deep, 3-port instance
    check("ready24_up", 64'(ready24), 64'd1);
    we24 = 1'b1; wr24 = 5'd30; wd24 = 32'hA5A5_A5A5;
    tick();
    wr24 = 5'd23; wd24 = 32'h2323_0023;
    tick();
    we24 = 1'b0;
    rr24 = {5'd23, 5'd23, 5'd30};
    #1;
    check("d24_p0_addr30", 64'(rd24[31:0]), 64'd0);
    check("d24_p1_addr23", 64'(rd24[63:32]), 64'h2323_0023);
    check("d24_p2_addr23", 64'(rd24[95:64]), 64'h2323_0023);
    rr24 = {5'd31, 5'd0, 5'd22};
    #1;
    check("d24_zero_ports", 64'(rd24[95:0] != '0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
